// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART bus master: FSM state encoding, frame
// command bytes and the fixed bus access size.
package uart_bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS_WR,
    BUS_RD,
    RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [1:0] MEM_WORD  = 2'b10;

endpackage

// File: rtl/uart_bus_master_timeout.sv
// Inter-byte timeout counter for the UART bus master.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (a byte arrived, or no frame is in progress)
//   expired    : count has reached TIMEOUT_CYCLES; holds until cleared
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count;

  assign expired = (count == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus master. Receives framed commands from a UART receiver,
// performs a single word write or read on the system bus while holding the
// core halted, and returns an ack byte, an error byte or the read word.
//   clk, rst_n        : clock, asynchronous active-low reset
//   rx_data/rx_valid  : received byte and its one-cycle strobe
//   tx_data/tx_valid  : response byte, held until tx_ready handshake
//   tx_ready          : transmitter accepts byte when high with tx_valid
//   bus_req           : halt / bus grant request, selects our bus outputs
//   bus_address/wd/we : bus access; address/wd read 0 while bus_req is low
//   bus_mem_ctrl      : access size, always word
//   bus_rd            : combinational read data
//   busy              : high whenever the FSM is not idle
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  ERR_BYTE       = 8'h45
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wd,
  output logic        bus_we,
  output logic [1:0]  bus_mem_ctrl,
  input  logic [31:0] bus_rd,
  output logic        busy
);

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  cnt_next;
  logic [1:0]  resp_last;
  logic        cmd_write;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic        collecting;
  logic        expired;

  assign cnt_next     = cnt + 2'd1;
  assign collecting   = (state == ADDR) || (state == DATA);
  assign busy         = (state != IDLE);
  assign bus_mem_ctrl = MEM_WORD;
  assign bus_address  = bus_req ? address : '0;
  assign bus_wd       = bus_req ? wdata : '0;

  // Counter is held clear outside ADDR/DATA so every frame starts from zero.
  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid || !collecting),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      resp_last <= '0;
      cmd_write <= 1'b0;
      address   <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
    end else begin
      bus_we <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            cnt <= '0;
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              cmd_write <= (rx_data == CMD_WRITE);
              bus_req   <= 1'b1;
              state     <= ADDR;
            end else begin
              resp_last <= 2'd0;
              tx_data   <= ERR_BYTE;
              tx_valid  <= 1'b1;
              state     <= RESP;
            end
          end
        end

        ADDR: begin
          if (rx_valid) begin
            address[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt_next;
            if (cnt == 2'd3) begin
              state <= cmd_write ? DATA : BUS_RD;
            end
          end else if (expired) begin
            bus_req <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end
        end

        DATA: begin
          if (rx_valid) begin
            wdata[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt_next;
            if (cnt == 2'd3) begin
              bus_we <= 1'b1;
              state  <= BUS_WR;
            end
          end else if (expired) begin
            bus_req <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end
        end

        BUS_WR: begin
          cnt       <= '0;
          resp_last <= 2'd0;
          tx_data   <= ACK_BYTE;
          tx_valid  <= 1'b1;
          state     <= RESP;
        end

        BUS_RD: begin
          // The first response byte comes straight from bus_rd so it is
          // presented in the same edge the word is captured.
          rbuf      <= bus_rd;
          cnt       <= '0;
          resp_last <= 2'd3;
          tx_data   <= bus_rd[7:0];
          tx_valid  <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          if (tx_ready) begin
            if (cnt == resp_last) begin
              tx_valid <= 1'b0;
              tx_data  <= '0;
              bus_req  <= 1'b0;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              tx_data <= rbuf[{cnt_next, 3'b000} +: 8];
              cnt     <= cnt_next;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
